pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/pipe_adder_stage.sv | 57 +++++
 rtl/pipe_adder.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and the stage-register record for the chunked pipelined adder.
package pipe_adder_pkg;

    localparam int unsigned PA_WIDTH = 16;
    localparam int unsigned PA_CHUNK = 4;

    // One pipeline stage worth of state. Operands shift right by one chunk per
    // stage so every stage adds the low chunk. Finished sum chunks enter at the top.
    typedef struct packed {
        logic                valid;
        logic                carry;
        logic                sub;
        logic                ov;
        logic [PA_WIDTH-1:0] sum;
        logic [PA_WIDTH-1:0] x;
        logic [PA_WIDTH-1:0] y;
    } stage_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// One CHUNK-bit slice of the pipelined adder plus its enabled stage register.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = PA_WIDTH,
    parameter int unsigned CHUNK = PA_CHUNK,
    parameter bit          LAST  = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en_i,
    input  stage_t stage_i,
    output stage_t stage_o
);

    localparam int unsigned CW = CHUNK + 1;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK-1:0] r_c;
    logic             c_c;
    stage_t           stage_d;
    stage_t           stage_q;

    // The incoming ov field is never meaningful; ov is computed only in the last slice.
    logic unused_ov;
    assign unused_ov = stage_i.ov;

    // Chunk add, then shift operands down and the new sum chunk in at the top.
    always_comb begin
        stage_d = '0;
        a_c     = stage_i.x[CHUNK-1:0];
        b_c     = stage_i.sub ? ~stage_i.y[CHUNK-1:0] : stage_i.y[CHUNK-1:0];
        {c_c, r_c} = CW'(a_c) + CW'(b_c) + CW'(stage_i.carry);

        stage_d.valid = stage_i.valid;
        stage_d.carry = c_c;
        stage_d.sub   = stage_i.sub;
        stage_d.sum   = (stage_i.sum >> CHUNK) | (WIDTH'(r_c) << (WIDTH - CHUNK));
        stage_d.x     = stage_i.x >> CHUNK;
        stage_d.y     = stage_i.y >> CHUNK;
        stage_d.ov    = LAST && (a_c[CHUNK-1] == b_c[CHUNK-1])
                             && (r_c[CHUNK-1] != a_c[CHUNK-1]);
    end

    // Stage register: cleared by reset, holds whenever the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple adder/subtractor, CHUNK bits per stage, valid/ready handshake.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = PA_WIDTH,
    parameter int unsigned CHUNK = PA_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    // The stage record is sized by the package width; only chunk size may vary.
    if (WIDTH != PA_WIDTH || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must equal PA_WIDTH and be a nonzero multiple of CHUNK");
    end

    logic   adv_c;
    stage_t head_c;
    stage_t pipe_q [STAGES];

    // Whole pipeline moves together; it stalls only when the held result is not taken.
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c;

    // Pack the presented operand set into the record entering stage 0.
    always_comb begin
        head_c       = '0;
        head_c.valid = in_valid;
        head_c.carry = ci;
        head_c.sub   = sub;
        head_c.x     = x;
        head_c.y     = y;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .LAST  (STAGES == 1)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (adv_c),
                .stage_i (head_c),
                .stage_o (pipe_q[k])
            );
        end else begin : g_next
            pipe_adder_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .LAST  (k == STAGES - 1)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (adv_c),
                .stage_i (pipe_q[k-1]),
                .stage_o (pipe_q[k])
            );
        end
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign s         = pipe_q[STAGES-1].sum;
    assign co        = pipe_q[STAGES-1].carry;
    assign ov        = pipe_q[STAGES-1].ov;

    // Operand remnants and sub leaving the last stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{pipe_q[STAGES-1].x, pipe_q[STAGES-1].y, pipe_q[STAGES-1].sub};

endmodule
